// File: rtl/tis_pkg.sv
`default_nettype none
// ==========================================================================
// tis_pkg : opcodes and default datapath constants for the TIS node
// Rev 1.0 : initial release
// ==========================================================================
package tis_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_MOV = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB = 3'd3;
    localparam logic [OP_W-1:0] OP_NEG = 3'd4;
    localparam logic [OP_W-1:0] OP_SAV = 3'd5;
    localparam logic [OP_W-1:0] OP_SWP = 3'd6;
    localparam logic [OP_W-1:0] OP_RSV = 3'd7;

    localparam int DEF_WIDTH = 11;
    localparam int DEF_MAX   = 999;
    localparam int DEF_MIN   = -999;

    // One guard bit is enough: |a +/- b| and |-a| never exceed twice the range.
    function automatic int ext_width(input int w);
        return w + 1;
    endfunction

    localparam int DEF_EXT_WIDTH = ext_width(DEF_WIDTH);

endpackage
`default_nettype wire

// File: rtl/tis_sat.sv
`default_nettype none
// ==========================================================================
// tis_sat : combinational signed clamp to [MIN, MAX] with a clamped flag
// Rev 1.0 : initial release
// ==========================================================================
module tis_sat #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 11,
    parameter int MIN   = -999,
    parameter int MAX   = 999
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clamped
);

    localparam logic signed [IN_W-1:0] MAX_IN = IN_W'(MAX);
    localparam logic signed [IN_W-1:0] MIN_IN = IN_W'(MIN);

    always_comb begin
        dout    = din[OUT_W-1:0];
        clamped = 1'b0;
        if (din > MAX_IN) begin
            dout    = OUT_W'(MAX);
            clamped = 1'b1;
        end else if (din < MIN_IN) begin
            dout    = OUT_W'(MIN);
            clamped = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tis_exec_unit.sv
`default_nettype none
// ==========================================================================
// tis_exec_unit : registered ACC/BAK execution unit with saturating ops
// Rev 1.0 : initial release
// ==========================================================================
module tis_exec_unit
    import tis_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_VAL = DEF_MAX,
    parameter int MIN_VAL = DEF_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_sat,
    output logic             acc_zero,
    output logic             acc_neg,
    output logic             acc_pos
);

    localparam int EXT_W = ext_width(WIDTH);

    logic signed [WIDTH-1:0] acc, bak;
    logic signed [WIDTH-1:0] src_c, res_c;
    logic signed [WIDTH-1:0] acc_nxt, bak_nxt;
    logic signed [EXT_W-1:0] acc_x, src_x, sum;
    logic                    src_sat, res_sat, op_sat;
    logic                    accept;

    tis_sat #(.IN_W(WIDTH), .OUT_W(WIDTH), .MIN(MIN_VAL), .MAX(MAX_VAL)) u_src_sat (
        .din     (in_src),
        .dout    (src_c),
        .clamped (src_sat)
    );

    assign acc_x = {acc[WIDTH-1], acc};
    assign src_x = {src_c[WIDTH-1], src_c};

    always_comb begin
        sum    = acc_x;
        op_sat = 1'b0;
        case (in_op)
            OP_MOV: sum = src_x;
            OP_ADD: sum = acc_x + src_x;
            OP_SUB: sum = acc_x - src_x;
            OP_NEG: sum = -acc_x;
            default: sum = acc_x;
        endcase
        case (in_op)
            OP_MOV, OP_ADD, OP_SUB: op_sat = src_sat | res_sat;
            OP_NEG:                 op_sat = res_sat;
            default:                op_sat = 1'b0;
        endcase
    end

    tis_sat #(.IN_W(EXT_W), .OUT_W(WIDTH), .MIN(MIN_VAL), .MAX(MAX_VAL)) u_res_sat (
        .din     (sum),
        .dout    (res_c),
        .clamped (res_sat)
    );

    // SAV/SWP/NOP never touch the adder result; only arithmetic ops load res_c.
    always_comb begin
        acc_nxt = acc;
        bak_nxt = bak;
        case (in_op)
            OP_MOV, OP_ADD, OP_SUB, OP_NEG: acc_nxt = res_c;
            OP_SAV: bak_nxt = acc;
            OP_SWP: begin
                acc_nxt = bak;
                bak_nxt = acc;
            end
            default: ;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            bak       <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            acc       <= acc_nxt;
            bak       <= bak_nxt;
            out_valid <= 1'b1;
            out_acc   <= acc_nxt;
            out_sat   <= op_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign acc_zero = (acc == '0);
    assign acc_neg  = acc[WIDTH-1];
    assign acc_pos  = !acc_zero && !acc_neg;

endmodule
`default_nettype wire

// File: tb/tb_tis_exec_unit.sv
`default_nettype none
// ==========================================================================
// tb_tis_exec_unit : directed scoreboard bench for tis_exec_unit
// Rev 1.0 : initial release
// ==========================================================================
module tb_tis_exec_unit;
    import tis_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [10:0] in_src = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_acc;
    logic        out_sat;
    logic        acc_zero, acc_neg, acc_pos;

    tis_exec_unit #(.WIDTH(11), .MAX_VAL(999), .MIN_VAL(-999)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src    (in_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat),
        .acc_zero  (acc_zero),
        .acc_neg   (acc_neg),
        .acc_pos   (acc_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   acc_m = 0;
    int   bak_m = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > 999)  return 999;
        if (v < -999) return -999;
        return v;
    endfunction

    // Reference model: independent integer arithmetic, updates acc_m/bak_m.
    task automatic model(input logic [2:0] op, input int src, output exp_t e);
        int sc, r, res, t;
        bit s;
        sc = clampv(src);
        s  = 1'b0;
        case (op)
            3'd1, 3'd2, 3'd3: begin
                r = (op == 3'd1) ? sc : (op == 3'd2) ? acc_m + sc : acc_m - sc;
                res = clampv(r);
                s = (sc != src) || (res != r);
                acc_m = res;
            end
            3'd4: begin
                r = -acc_m;
                res = clampv(r);
                s = (res != r);
                acc_m = res;
            end
            3'd5: bak_m = acc_m;
            3'd6: begin
                t = acc_m;
                acc_m = bak_m;
                bak_m = t;
            end
            default: ;
        endcase
        e.acc = acc_m;
        e.sat = int'(s);
    endtask

    // Called at posedge+1; returns at the posedge+1 after acceptance.
    task automatic issue(input logic [2:0] op, input int src);
        bit   ok;
        exp_t e;
        in_op    = op;
        in_src   = 11'(src);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("accept", int'(ok), 1);
        if (ok) begin
            model(op, src, e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL sb_unexpected observed=%0d expected=none", $signed(out_acc));
            end else begin
                e = sb.pop_front();
                chk("out_acc", int'($signed(out_acc)), e.acc);
                chk("out_sat", int'(out_sat), e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int held;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_acc", int'($signed(out_acc)), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_zero", int'(acc_zero), 1);
        chk("rst_neg", int'(acc_neg), 0);
        chk("rst_pos", int'(acc_pos), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Back-to-back basic arithmetic
        issue(OP_MOV, 5);
        issue(OP_ADD, 7);
        issue(OP_SUB, 20);
        @(negedge clk);
        chk("flag_neg", int'(acc_neg), 1);
        chk("flag_zero", int'(acc_zero), 0);
        chk("flag_pos", int'(acc_pos), 0);
        @(posedge clk);
        #1;

        // Result saturation at both rails
        issue(OP_MOV, 900);
        issue(OP_ADD, 200);
        issue(OP_SUB, 999);
        issue(OP_SUB, 999);
        issue(OP_SUB, 1);

        // Source clamp
        issue(OP_MOV, 1023);
        issue(OP_MOV, -1024);

        // Register ops and reserved opcode
        issue(OP_MOV, 42);
        issue(OP_SAV, 0);
        issue(OP_NEG, 0);
        issue(OP_SWP, 0);
        issue(OP_RSV, 123);
        @(negedge clk);
        chk("flag_pos", int'(acc_pos), 1);
        @(posedge clk);
        #1;

        // Backpressure: result held, next op queued until release
        issue(OP_MOV, 1);
        out_ready = 1'b0;
        in_op     = OP_ADD;
        in_src    = 11'(2);
        in_valid  = 1'b1;
        held      = acc_m;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_acc", int'($signed(out_acc)), held);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        model(OP_ADD, 2, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        issue(OP_ADD, 10);

        // Reset with a pending result and a presented request
        issue(OP_MOV, 100);
        out_ready = 1'b0;
        in_op     = OP_ADD;
        in_src    = 11'(5);
        in_valid  = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        acc_m = 0;
        bak_m = 0;
        @(negedge clk);
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_out_acc", int'($signed(out_acc)), 0);
        chk("rst2_zero", int'(acc_zero), 1);
        @(posedge clk);
        #1;
        issue(OP_SWP, 0);
        issue(OP_ADD, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
